fetch_unit: RTL and testbench

- Instruction fetch stage: owns the PC, issues requests to a synchronous-read instruction memory, and presents `{pc, pc+4, instr}` with a valid flag to the IF/ID pipeline register.
- Absorbs downstream stalls with a one-entry hold register, so no fetched word is lost or duplicated.
- Redirects immediately on branch/jump resolution and kills wrong-path fetches.

---
 rtl/fetch_unit_if.sv | 42 ++++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups every fetch-stage signal except clock and reset.
//   master modport : the fetch unit (drives the imem request and the IF/ID outputs)
//   slave modport  : the surroundings (IF/ID control, branch unit, instruction memory)
// Signals:
//   stall_i        downstream not accepting this cycle
//   redirect_i     taken branch/jump, refetch from redirect_pc_i
//   redirect_pc_i  redirect target
//   imem_req_o     fetch request this cycle
//   imem_addr_o    fetch address
//   imem_rdata_i   instruction word, valid the cycle after imem_req_o
//   valid_o        pc_o/pc_four_o/instr_o carry a real instruction
//   pc_o           PC of instr_o
//   pc_four_o      pc_o + 4
//   instr_o        fetched instruction
//   fetch_cnt_o    accepted-instruction count
//   bubble_cnt_o   bubble-cycle count
interface fetch_unit_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] pc_four_o;
    logic [31:0] instr_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, valid_o, pc_o, pc_four_o, instr_o,
               fetch_cnt_o, bubble_cnt_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, valid_o, pc_o, pc_four_o, instr_o,
               fetch_cnt_o, bubble_cnt_o
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues requests to a
// synchronous-read instruction memory and presents {pc, pc+4, instr} with a
// valid flag to the IF/ID register. A one-entry hold register absorbs
// downstream stalls; a redirect kills wrong-path fetches and refetches at once.
// Ports:
//   clk_i  clock, all state on the rising edge
//   rst_i  synchronous active-high reset
//   bus    fetch_unit_if.master (stall/redirect in, imem request/response,
//          IF/ID outputs, performance counters)
// Parameters:
//   RESET_PC  first fetch address after reset
// Optional feature:
//   FETCH_PERF_EN  when defined, fetch_cnt_o counts accepts and bubble_cnt_o
//                  counts non-reset cycles with valid_o low; otherwise both
//                  outputs are tied to 0 and no counter flops exist.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_unit_if.master  bus
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    logic [31:0] pc_q;
    logic        rsp_vld_q;
    logic [31:0] rsp_pc_q;
    logic        hold_vld_q;
    fetch_ent_t  hold_q;

    logic        valid;
    logic        accept;
    logic        req;
    logic [31:0] addr;
    fetch_ent_t  cur;

    // The hold entry, when present, is always older than any response, and
    // the two are never valid together (no request issues while stalled).
    always_comb begin
        cur = hold_vld_q ? hold_q : '{pc: rsp_pc_q, instr: bus.imem_rdata_i};
    end

    assign valid  = (hold_vld_q | rsp_vld_q) & ~bus.redirect_i & ~rst_i;
    assign accept = valid & ~bus.stall_i;
    assign req    = ~bus.stall_i & ~rst_i;
    assign addr   = bus.redirect_i ? bus.redirect_pc_i : pc_q;

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = addr;
    assign bus.valid_o     = valid;
    // Data is gated to zero whenever nothing valid is presented, so an idle
    // or post-reset stage never shows stale memory contents.
    assign bus.pc_o        = valid ? cur.pc : 32'h0;
    assign bus.pc_four_o   = valid ? cur.pc + 32'd4 : 32'h0;
    assign bus.instr_o     = valid ? cur.instr : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            rsp_vld_q  <= 1'b0;
            rsp_pc_q   <= 32'h0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            // Request side. A redirect under stall parks the target in pc_q
            // so it is the first address issued once the stall drops.
            if (req) begin
                pc_q      <= addr + 32'd4;
                rsp_vld_q <= 1'b1;
                rsp_pc_q  <= addr;
            end else begin
                rsp_vld_q <= 1'b0;
                if (bus.redirect_i)
                    pc_q <= bus.redirect_pc_i;
            end

            // Hold entry. A redirect discards it; the in-flight response is
            // discarded implicitly since valid_o is low in the redirect cycle.
            if (bus.redirect_i) begin
                hold_vld_q <= 1'b0;
            end else if (bus.stall_i && rsp_vld_q && !hold_vld_q) begin
                hold_vld_q   <= 1'b1;
                hold_q.pc    <= rsp_pc_q;
                hold_q.instr <= bus.imem_rdata_i;
            end else if (accept && hold_vld_q) begin
                hold_vld_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (accept)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (!valid)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_cnt_o  = fetch_cnt_q;
    assign bus.bubble_cnt_o = bubble_cnt_q;
`else
    assign bus.fetch_cnt_o  = 32'h0;
    assign bus.bubble_cnt_o = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Two instances share clock and
// reset: dut0 (RESET_PC = 0) takes the directed stall/redirect vectors, dut1
// (RESET_PC = 0xFFFFFFF8) free-runs to cover PC wrap. Each has a memory model
// that returns the request address as the instruction word.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    fetch_unit_if bus0 ();
    fetch_unit_if bus1 ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.master));
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.master));

    always #5 clk = ~clk;

    // Synchronous-read memory: word = address.
    always @(posedge clk) begin
        if (rst) bus0.imem_rdata_i <= 32'h0;
        else if (bus0.imem_req_o) bus0.imem_rdata_i <= bus0.imem_addr_o;
    end
    always @(posedge clk) begin
        if (rst) bus1.imem_rdata_i <= 32'h0;
        else if (bus1.imem_req_o) bus1.imem_rdata_i <= bus1.imem_addr_o;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Checks one cycle of dut0 against hand-computed expectations.
    task automatic exp_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic req, input logic [31:0] addr);
        chk({tag, ".valid"}, {31'b0, bus0.valid_o}, {31'b0, v});
        if (v) begin
            chk({tag, ".pc"},    bus0.pc_o,      pc);
            chk({tag, ".pc4"},   bus0.pc_four_o, pc + 32'd4);
            chk({tag, ".instr"}, bus0.instr_o,   pc);
        end
        chk({tag, ".req"}, {31'b0, bus0.imem_req_o}, {31'b0, req});
        if (req) chk({tag, ".addr"}, bus0.imem_addr_o, addr);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus0.stall_i = 1'b0; bus0.redirect_i = 1'b0; bus0.redirect_pc_i = 32'h0;
        bus1.stall_i = 1'b0; bus1.redirect_i = 1'b0; bus1.redirect_pc_i = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.valid", {31'b0, bus0.valid_o},    32'h0);
        chk("rst.req",   {31'b0, bus0.imem_req_o}, 32'h0);
        chk("rst.fcnt",  bus0.fetch_cnt_o,  32'h0);
        chk("rst.bcnt",  bus0.bubble_cnt_o, 32'h0);
        next_cyc();
        rst = 1'b0;

        // c0: first request at RESET_PC, nothing valid yet
        @(negedge clk);
        exp_out("c0", 1'b0, 32'h0, 1'b1, 32'h0);
        chk("c0.pc0",    bus0.pc_o,      32'h0);
        chk("c0.pc4z",   bus0.pc_four_o, 32'h0);
        chk("c0.instr0", bus0.instr_o,   32'h0);
        chk("c0.fcnt",   bus0.fetch_cnt_o,  32'h0);
        chk("c0.bcnt",   bus0.bubble_cnt_o, 32'h0);
        chk("w0.addr",   bus1.imem_addr_o,  32'hFFFF_FFF8);
        next_cyc();
        @(negedge clk);
        exp_out("c1", 1'b1, 32'h0, 1'b1, 32'h4);
        chk("w1.pc", bus1.pc_o, 32'hFFFF_FFF8);
        next_cyc();
        @(negedge clk);
        exp_out("c2", 1'b1, 32'h4, 1'b1, 32'h8);
        chk("w2.pc",  bus1.pc_o,      32'hFFFF_FFFC);
        chk("w2.pc4", bus1.pc_four_o, 32'h0);
        next_cyc();

        // Stall three cycles with 0x8 in flight
        bus0.stall_i = 1'b1;
        @(negedge clk);
        exp_out("c3", 1'b1, 32'h8, 1'b0, 32'h0);
        chk("w3.pc",    bus1.pc_o,    32'h0);
        chk("w3.instr", bus1.instr_o, 32'h0);
        next_cyc();
        @(negedge clk);
        exp_out("c4", 1'b1, 32'h8, 1'b0, 32'h0);
        next_cyc();
        @(negedge clk);
        exp_out("c5", 1'b1, 32'h8, 1'b0, 32'h0);
        next_cyc();
        bus0.stall_i = 1'b0;
        @(negedge clk);
        exp_out("c6", 1'b1, 32'h8, 1'b1, 32'hC);
        next_cyc();
        @(negedge clk);
        exp_out("c7", 1'b1, 32'hC, 1'b1, 32'h10);
        next_cyc();

        // Redirect to 0x100 while 0x10 is in flight
        bus0.redirect_i = 1'b1; bus0.redirect_pc_i = 32'h100;
        @(negedge clk);
        exp_out("c8", 1'b0, 32'h0, 1'b1, 32'h100);
        next_cyc();
        bus0.redirect_i = 1'b0;
        @(negedge clk);
        exp_out("c9", 1'b1, 32'h100, 1'b1, 32'h104);
        next_cyc();

        // Fill hold with 0x104, then redirect to 0x200 under stall
        bus0.stall_i = 1'b1;
        @(negedge clk);
        exp_out("c10", 1'b1, 32'h104, 1'b0, 32'h0);
        next_cyc();
        bus0.redirect_i = 1'b1; bus0.redirect_pc_i = 32'h200;
        @(negedge clk);
        exp_out("c11", 1'b0, 32'h0, 1'b0, 32'h0);
        next_cyc();
        bus0.redirect_i = 1'b0;
        @(negedge clk);
        exp_out("c12", 1'b0, 32'h0, 1'b0, 32'h0);
        next_cyc();
        bus0.stall_i = 1'b0;
        @(negedge clk);
        exp_out("c13", 1'b0, 32'h0, 1'b1, 32'h200);
        next_cyc();
        @(negedge clk);
        exp_out("c14", 1'b1, 32'h200, 1'b1, 32'h204);
        next_cyc();

        // Reset mid-operation, then 10 accepts and 3 bubbles
        rst = 1'b1;
        @(negedge clk);
        exp_out("c15", 1'b0, 32'h0, 1'b0, 32'h0);
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        exp_out("p0", 1'b0, 32'h0, 1'b1, 32'h0);
        next_cyc();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            exp_out($sformatf("p%0d", i), 1'b1, 32'(i - 1) * 32'd4, 1'b1, 32'(i) * 32'd4);
            next_cyc();
        end
        bus0.redirect_i = 1'b1; bus0.redirect_pc_i = 32'h300;
        @(negedge clk);
        exp_out("p10", 1'b0, 32'h0, 1'b1, 32'h300);
        next_cyc();
        bus0.redirect_i = 1'b0;
        @(negedge clk);
        exp_out("p11", 1'b1, 32'h300, 1'b1, 32'h304);
        next_cyc();
        bus0.redirect_i = 1'b1; bus0.redirect_pc_i = 32'h400;
        @(negedge clk);
        exp_out("p12", 1'b0, 32'h0, 1'b1, 32'h400);
        next_cyc();
        bus0.redirect_i = 1'b0;
        @(negedge clk);
        exp_out("p13", 1'b1, 32'h400, 1'b1, 32'h404);
`ifdef FETCH_PERF_EN
        chk("p13.fcnt", bus0.fetch_cnt_o,  32'd10);
        chk("p13.bcnt", bus0.bubble_cnt_o, 32'd3);
`else
        chk("p13.fcnt", bus0.fetch_cnt_o,  32'd0);
        chk("p13.bcnt", bus0.bubble_cnt_o, 32'd0);
`endif
        next_cyc();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
